// File: rtl/bldc_commutation_sequencer.sv
// BLDC commutation sequencer: hall sync/filter, sector decode,
// dead-time insertion, fault blanking and stall detection.
module bldc_commutation_sequencer #(
  parameter int DEADTIME_CYCLES = 16,
  parameter int HALL_FILTER     = 4,
  parameter int STALL_TIMEOUT   = 1_600_000
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       dir,
  input  logic [2:0] hall,
  input  logic       fault_n,
  input  logic       clear_fault,
  input  logic       pwm_in,
  output logic       INHA,
  output logic       INHB,
  output logic       INHC,
  output logic       INLA,
  output logic       INLB,
  output logic       INLC,
  output logic [2:0] sector,
  output logic       commutated,
  output logic       hall_error,
  output logic       fault,
  output logic       stall
);

  localparam int FW = $clog2(HALL_FILTER + 1);
  localparam int DW = $clog2(DEADTIME_CYCLES + 1);
  localparam int SW = 21;
  localparam logic [FW-1:0] FILT_N = FW'(HALL_FILTER);
  localparam logic [DW-1:0] DT_N   = DW'(DEADTIME_CYCLES);
  localparam logic [SW-1:0] ST_N   = SW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DEADTIME,
    DRIVE,
    FAULT
  } state_t;

  state_t        state, state_d;
  logic [2:0]    h_s1, h_s2, h_prev, h_acc, dec;
  logic          h_have, f_s1, f_s2, accept;
  logic [FW-1:0] f_cnt;
  logic [DW-1:0] dt_cnt, dt_d;
  logic [5:0]    tgt, last_tgt;
  logic [2:0]    gh, gl;
  logic [SW-1:0] scnt, scnt_d;
  logic          chg, ok_drive, active_d;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      h_s1 <= '0;
      h_s2 <= '0;
      f_s1 <= 1'b1;
      f_s2 <= 1'b1;
    end else begin
      h_s1 <= hall;
      h_s2 <= h_s1;
      f_s1 <= fault_n;
      f_s2 <= f_s1;
    end
  end

  // f_cnt = length of the current run of identical samples
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      h_prev <= '0;
      f_cnt  <= '0;
    end else begin
      h_prev <= h_s2;
      if (h_s2 != h_prev)
        f_cnt <= FW'(1);
      else if (f_cnt != FILT_N)
        f_cnt <= f_cnt + FW'(1);
    end
  end

  assign accept = (f_cnt == FILT_N) &&
                  (!h_have || (h_prev != h_acc));

  always_comb begin
    dec = 3'd7;
    case (h_prev)
      3'b101:  dec = 3'd0;
      3'b100:  dec = 3'd1;
      3'b110:  dec = 3'd2;
      3'b010:  dec = 3'd3;
      3'b011:  dec = 3'd4;
      3'b001:  dec = 3'd5;
      default: dec = 3'd7;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      h_acc      <= '0;
      h_have     <= 1'b0;
      sector     <= 3'd7;
      commutated <= 1'b0;
      hall_error <= 1'b0;
    end else begin
      commutated <= 1'b0;
      if (accept) begin
        h_acc      <= h_prev;
        h_have     <= 1'b1;
        sector     <= dec;
        hall_error <= (dec == 3'd7);
        commutated <= (dec != 3'd7);
      end
    end
  end

  // tgt = {HA,HB,HC,LA,LB,LC}
  always_comb begin
    tgt = '0;
    case (sector)
      3'd0:    tgt = dir ? 6'b001_010 : 6'b010_001;
      3'd1:    tgt = dir ? 6'b100_010 : 6'b010_100;
      3'd2:    tgt = dir ? 6'b100_001 : 6'b001_100;
      3'd3:    tgt = dir ? 6'b010_001 : 6'b001_010;
      3'd4:    tgt = dir ? 6'b010_100 : 6'b100_010;
      3'd5:    tgt = dir ? 6'b001_100 : 6'b100_001;
      default: tgt = '0;
    endcase
  end

  assign chg      = (tgt != last_tgt);
  assign ok_drive = enable && (sector != 3'd7);

  always_comb begin
    state_d = state;
    dt_d    = dt_cnt;
    if (!f_s2) begin
      state_d = FAULT;
    end else begin
      unique case (state)
        IDLE: begin
          if (ok_drive) begin
            state_d = DEADTIME;
            dt_d    = DT_N;
          end
        end
        DEADTIME: begin
          if (!ok_drive)
            state_d = IDLE;
          else if (chg)
            dt_d = DT_N;
          else if (dt_cnt == DW'(1))
            state_d = DRIVE;
          else
            dt_d = dt_cnt - DW'(1);
        end
        DRIVE: begin
          if (!ok_drive) begin
            state_d = IDLE;
          end else if (chg) begin
            state_d = DEADTIME;
            dt_d    = DT_N;
          end
        end
        FAULT: begin
          if (clear_fault)
            state_d = IDLE;
        end
      endcase
    end
  end

  assign active_d = (state_d == DEADTIME) || (state_d == DRIVE);

  always_comb begin
    scnt_d = '0;
    if (!commutated && active_d)
      scnt_d = (scnt == ST_N) ? scnt : scnt + SW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state    <= IDLE;
      dt_cnt   <= '0;
      last_tgt <= '0;
      gh       <= '0;
      gl       <= '0;
      fault    <= 1'b0;
      scnt     <= '0;
      stall    <= 1'b0;
    end else begin
      state    <= state_d;
      dt_cnt   <= dt_d;
      last_tgt <= tgt;
      gh       <= (state_d == DRIVE) ? tgt[5:3] : 3'b000;
      gl       <= (state_d == DRIVE) ? tgt[2:0] : 3'b000;
      fault    <= (state_d == FAULT);
      scnt     <= scnt_d;
      if (commutated || !enable)
        stall <= 1'b0;
      else if (scnt_d == ST_N)
        stall <= 1'b1;
    end
  end

  assign INHA = gh[2] & pwm_in;
  assign INHB = gh[1] & pwm_in;
  assign INHC = gh[0] & pwm_in;
  assign INLA = gl[2];
  assign INLB = gl[1];
  assign INLC = gl[0];

endmodule
